usb_packet_tx: RTL

- Parametrised, re-triggerable successor to the one-shot USB packet encoder. It accepts a packet request (PID plus optional 11-bit token field or payload stream), serialises PID, body and CRC LSB-first, and drives an internal jk_encoder, which owns SYNC, bit stuffing, NRZI and EOP.
- It sits between the endpoint/protocol engine and the USB full-speed pads.
- New capabilities:
  - Covers all packet classes: token, SOF, data, zero-length data and handshake.
  - Valid/ready byte streaming.
  - Payload length limit.
  - Underrun and overflow detection.
  - Back-to-back packets without reset.

---
 rtl/usb_packet_tx.sv | 366 ++++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/usb_packet_tx.sv
// USB full-speed packet transmitter: serialises PID, token/payload and CRC LSB-first
// into an embedded J/K line encoder that owns SYNC, bit stuffing, NRZI and EOP.

module usb_jk_encoder (
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  input  logic bit_in_i,
  input  logic last_bit_i,
  output logic bit_ack_o,
  output logic done_o,
  output logic dp_o,
  output logic dn_o
);

  typedef enum logic [1:0] {J_IDLE, J_SYNC, J_DATA, J_EOP} jstate_t;

  jstate_t    st_q, st_d;
  logic [1:0] ph_q, ph_d;
  logic [2:0] idx_q, idx_d;
  logic [2:0] ones_q, ones_d;
  logic       lvl_q, lvl_d;
  logic       se0_q, se0_d;
  logic       last_q, last_d;
  logic       tick;

  // One bit period is four 48 MHz cycles; lvl_q=1 is J.
  assign tick = (ph_q == 2'd3);
  assign dp_o = lvl_q & ~se0_q;
  assign dn_o = ~lvl_q & ~se0_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q   <= J_IDLE;
      ph_q   <= 2'd0;
      idx_q  <= 3'd0;
      ones_q <= 3'd0;
      lvl_q  <= 1'b1;
      se0_q  <= 1'b0;
      last_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      ph_q   <= ph_d;
      idx_q  <= idx_d;
      ones_q <= ones_d;
      lvl_q  <= lvl_d;
      se0_q  <= se0_d;
      last_q <= last_d;
    end
  end

  always_comb begin
    st_d      = st_q;
    ph_d      = (st_q == J_IDLE) ? 2'd0 : ph_q + 2'd1;
    idx_d     = idx_q;
    ones_d    = ones_q;
    lvl_d     = lvl_q;
    se0_d     = se0_q;
    last_d    = last_q;
    bit_ack_o = 1'b0;
    done_o    = 1'b0;
    case (st_q)
      J_IDLE: begin
        if (start_i) begin
          st_d   = J_SYNC;
          idx_d  = 3'd0;
          ones_d = 3'd0;
          last_d = 1'b0;
          lvl_d  = ~lvl_q;
        end
      end
      J_SYNC, J_DATA: begin
        if (tick) begin
          if (st_q == J_SYNC && idx_q != 3'd7) begin
            // SYNC is 0000_0001; its trailing 1 counts toward the stuffing run.
            idx_d = idx_q + 3'd1;
            if (idx_q == 3'd6) begin
              ones_d = 3'd1;
            end else begin
              lvl_d  = ~lvl_q;
              ones_d = 3'd0;
            end
          end else if (ones_q == 3'd6) begin
            st_d   = J_DATA;
            lvl_d  = ~lvl_q;
            ones_d = 3'd0;
          end else if (last_q) begin
            st_d  = J_EOP;
            se0_d = 1'b1;
            idx_d = 3'd0;
          end else begin
            st_d      = J_DATA;
            bit_ack_o = 1'b1;
            last_d    = last_bit_i;
            if (bit_in_i) begin
              ones_d = ones_q + 3'd1;
            end else begin
              lvl_d  = ~lvl_q;
              ones_d = 3'd0;
            end
          end
        end
      end
      J_EOP: begin
        if (tick) begin
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd1) begin
            se0_d = 1'b0;
            lvl_d = 1'b1;
          end
          if (idx_q == 3'd2) begin
            done_o = 1'b1;
            st_d   = J_IDLE;
          end
        end
      end
      default: st_d = J_IDLE;
    endcase
  end

endmodule

module usb_packet_tx #(
  parameter int MAX_BYTES = 64,
  parameter int CNT_W     = $clog2(MAX_BYTES + 1)
) (
  input  logic             clk48,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       pid,
  input  logic [10:0]      token_field,
  input  logic [7:0]       byte_in,
  input  logic             byte_valid,
  input  logic             last_byte,
  output logic             byte_ack,
  output logic             dp,
  output logic             dn,
  output logic             idle,
  output logic             done,
  output logic             err_underrun,
  output logic             err_overflow,
  output logic [CNT_W-1:0] tx_count
);

  typedef enum logic [2:0] {S_IDLE, S_PID, S_TOKEN, S_PAYLOAD, S_CRC, S_WAIT_EOP} state_t;

  state_t           state_q, state_d;
  logic             need_q, need_d;
  logic             last_byte_q, last_byte_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [4:0]       crc5_q, crc5_d;
  logic [15:0]      crc16_q, crc16_d;
  logic [3:0]       pid_q, pid_d;
  logic [10:0]      tok_q, tok_d;
  logic [7:0]       byte_q, byte_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             bit_q, bit_d;
  logic             lastb_q, lastb_d;
  logic             crc_long_q, crc_long_d;
  logic             jk_start, jk_ack, jk_done, jk_rst;
  logic [7:0]       pid_byte;

  function automatic logic is_token(input logic [3:0] p);
    return (p == 4'b0001) || (p == 4'b1001) || (p == 4'b0101) || (p == 4'b1101);
  endfunction

  function automatic logic is_data(input logic [3:0] p);
    return (p == 4'b0011) || (p == 4'b1011);
  endfunction

  // Reflected (LSB-first) CRC steps, one bit per acknowledged bus bit.
  function automatic logic [4:0] crc5_step(input logic [4:0] c, input logic b);
    return (c >> 1) ^ ((c[0] ^ b) ? 5'h14 : 5'h00);
  endfunction

  function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic b);
    return (c >> 1) ^ ((c[0] ^ b) ? 16'hA001 : 16'h0000);
  endfunction

  assign pid_byte = {~pid_q, pid_q};
  assign jk_rst   = ~reset;
  assign tx_count = count_q;

  usb_jk_encoder u_jk (
    .clk       (clk48),
    .rst       (jk_rst),
    .start_i   (jk_start),
    .bit_in_i  (bit_q),
    .last_bit_i(lastb_q),
    .bit_ack_o (jk_ack),
    .done_o    (jk_done),
    .dp_o      (dp),
    .dn_o      (dn)
  );

  always_ff @(posedge clk48) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      need_q      <= 1'b0;
      last_byte_q <= 1'b0;
      count_q     <= '0;
      crc5_q      <= 5'h00;
      crc16_q     <= 16'h0000;
    end else begin
      state_q     <= state_d;
      need_q      <= need_d;
      last_byte_q <= last_byte_d;
      count_q     <= count_d;
      crc5_q      <= crc5_d;
      crc16_q     <= crc16_d;
    end
  end

  always_ff @(posedge clk48) begin
    pid_q      <= pid_d;
    tok_q      <= tok_d;
    byte_q     <= byte_d;
    cnt_q      <= cnt_d;
    bit_q      <= bit_d;
    lastb_q    <= lastb_d;
    crc_long_q <= crc_long_d;
  end

  always_comb begin
    state_d      = state_q;
    need_d       = need_q;
    last_byte_d  = last_byte_q;
    count_d      = count_q;
    crc5_d       = crc5_q;
    crc16_d      = crc16_q;
    pid_d        = pid_q;
    tok_d        = tok_q;
    byte_d       = byte_q;
    cnt_d        = cnt_q;
    bit_d        = bit_q;
    lastb_d      = lastb_q;
    crc_long_d   = crc_long_q;
    idle         = 1'b0;
    done         = 1'b0;
    byte_ack     = 1'b0;
    err_underrun = 1'b0;
    err_overflow = 1'b0;
    jk_start     = 1'b0;

    case (state_q)
      S_IDLE: begin
        idle = 1'b1;
        if (start) begin
          pid_d    = pid;
          tok_d    = token_field;
          count_d  = '0;
          bit_d    = pid[0];
          lastb_d  = 1'b0;
          cnt_d    = 4'd0;
          jk_start = 1'b1;
          state_d  = S_PID;
        end
      end
      S_WAIT_EOP: begin
        if (jk_done) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: ;
    endcase

    // The encoder consumed bit_q: account for it and pick the next phase.
    if (jk_ack) begin
      need_d = 1'b1;
      cnt_d  = cnt_q + 4'd1;
      case (state_q)
        S_PID: begin
          if (cnt_q == 4'd7) begin
            if (is_token(pid_q)) begin
              state_d = S_TOKEN;
              cnt_d   = 4'd0;
              crc5_d  = 5'h1F;
            end else if (is_data(pid_q)) begin
              state_d = S_PAYLOAD;
              cnt_d   = 4'd8;
              crc16_d = 16'hFFFF;
            end else begin
              state_d = S_WAIT_EOP;
            end
          end
        end
        S_TOKEN: begin
          crc5_d = crc5_step(crc5_q, bit_q);
          if (cnt_q == 4'd10) begin
            state_d    = S_CRC;
            cnt_d      = 4'd0;
            crc_long_d = 1'b0;
          end
        end
        S_PAYLOAD: begin
          crc16_d = crc16_step(crc16_q, bit_q);
          if (cnt_q == 4'd7) begin
            byte_ack = 1'b1;
            cnt_d    = 4'd8;
            if (last_byte_q) begin
              state_d    = S_CRC;
              cnt_d      = 4'd0;
              crc_long_d = 1'b1;
            end
          end
        end
        S_CRC: begin
          if (cnt_q == (crc_long_q ? 4'd15 : 4'd4)) state_d = S_WAIT_EOP;
        end
        default: ;
      endcase
    end

    // Cycle after an ack: register the next bit onto the encoder input.
    if (need_q) begin
      need_d = 1'b0;
      case (state_q)
        S_PID: begin
          bit_d   = pid_byte[cnt_q[2:0]];
          lastb_d = (cnt_q == 4'd7) && !is_token(pid_q) && !is_data(pid_q);
        end
        S_TOKEN: bit_d = tok_q[cnt_q];
        S_PAYLOAD: begin
          if (cnt_q == 4'd8) begin
            if (byte_valid) begin
              byte_d  = byte_in;
              bit_d   = byte_in[0];
              lastb_d = 1'b0;
              cnt_d   = 4'd0;
              count_d = count_q + CNT_W'(1);
              if (last_byte) begin
                last_byte_d = 1'b1;
              end else if (count_q == CNT_W'(MAX_BYTES - 1)) begin
                last_byte_d  = 1'b1;
                err_overflow = 1'b1;
              end else begin
                last_byte_d = 1'b0;
              end
            end else if (last_byte && count_q == '0) begin
              state_d    = S_CRC;
              cnt_d      = 4'd0;
              crc_long_d = 1'b1;
              bit_d      = ~crc16_q[0];
              lastb_d    = 1'b0;
            end else begin
              // Abort: one closing bit, no CRC, so the receiver sees a bad packet.
              err_underrun = 1'b1;
              state_d      = S_WAIT_EOP;
              bit_d        = 1'b0;
              lastb_d      = 1'b1;
            end
          end else begin
            bit_d = byte_q[cnt_q[2:0]];
          end
        end
        S_CRC: begin
          bit_d   = crc_long_q ? ~crc16_q[cnt_q] : ~crc5_q[cnt_q[2:0]];
          lastb_d = (cnt_q == (crc_long_q ? 4'd15 : 4'd4));
        end
        default: ;
      endcase
    end
  end

endmodule
